// File: rtl/serial_write_buffer.sv
// Parallel-in, MSB-first serial-out transmit stage; 1-cycle latency from start/write_sig to line, no backpressure (start ignored while busy).
// Optional even-parity trailer bit enabled by defining WRITE_BUF_PARITY_EN.
module serial_write_buffer #(
  parameter int   BUF_SIZE = 8,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                start,
  input  logic                write_sig,
  input  logic [BUF_SIZE-1:0] data_in,
  output logic                data_out,
  output logic                busy,
  output logic                done_sig
);

`ifdef WRITE_BUF_PARITY_EN
  localparam int NBITS = BUF_SIZE + 1;
`else
  localparam int NBITS = BUF_SIZE;
`endif
  localparam int CW = $clog2(BUF_SIZE + 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [BUF_SIZE-1:0] sreg_q, sreg_d;
  logic                dout_d, busy_d, done_d;
`ifdef WRITE_BUF_PARITY_EN
  logic                par_q, par_d;
`endif

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      data_out <= IDLE_VAL;
      busy     <= 1'b0;
      done_sig <= 1'b0;
`ifdef WRITE_BUF_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      data_out <= dout_d;
      busy     <= busy_d;
      done_sig <= done_d;
`ifdef WRITE_BUF_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    dout_d  = data_out;
    busy_d  = busy;
    done_d  = 1'b0;
`ifdef WRITE_BUF_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        // A coincident write_sig is dropped so the MSB gets a full bit period.
        if (start) begin
          sreg_d  = data_in;
          dout_d  = data_in[BUF_SIZE-1];
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef WRITE_BUF_PARITY_EN
          par_d   = ^data_in;
`endif
        end
      end
      SHIFT: begin
        if (write_sig) begin
          cnt_d  = cnt_inc;
          sreg_d = sreg_q << 1;
          if (cnt_inc < CW'(NBITS)) begin
`ifdef WRITE_BUF_PARITY_EN
            if (cnt_inc < CW'(BUF_SIZE)) dout_d = sreg_q[BUF_SIZE-2];
            else                         dout_d = par_q;
`else
            dout_d = sreg_q[BUF_SIZE-2];
`endif
          end else begin
            dout_d  = IDLE_VAL;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_write_buffer.sv
// Bench for serial_write_buffer: directed vector table, corner-case sequences, loopback receiver and randomized queue-model comparison.
module tb_serial_write_buffer;
  localparam int   W  = 8;
  localparam logic IV = 1'b0;
`ifdef WRITE_BUF_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         sys_clk = 1'b0;
  logic         rst = 1'b1, start = 1'b0, write_sig = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_out, busy, done_sig;

  serial_write_buffer #(.BUF_SIZE(W), .IDLE_VAL(IV)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .start    (start),
    .write_sig(write_sig),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done_sig (done_sig)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the word becomes a queue of line bits; each pulse drops the front bit.
  bit           m_q[$];
  bit           dummy;
  logic         m_out, m_busy, m_done;
  logic [W-1:0] cur_word;
  bit           rx_q[$];

  task automatic model(input logic r, input logic s, input logic w, input logic [W-1:0] d);
    m_done = 1'b0;
    if (r) begin
      m_q.delete();
      m_busy = 1'b0;
      m_out  = IV;
    end else if (!m_busy) begin
      if (s) begin
        m_q.delete();
        for (int i = W - 1; i >= 0; i--) m_q.push_back(d[i]);
        if (NB > W) m_q.push_back(^d);
        m_busy = 1'b1;
        m_out  = m_q[0];
      end
    end else if (w) begin
      dummy = m_q.pop_front();
      if (m_q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_out  = IV;
      end else begin
        m_out = m_q[0];
      end
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic w, input logic [W-1:0] d,
                     input string tag);
    logic [W-1:0] rx_word;
    // Loopback receiver: samples the line on every pulse while a word is in flight.
    if (!r && w && busy === 1'b1) rx_q.push_back(data_out);
    if (!r && s && !m_busy) begin
      rx_q.delete();
      cur_word = d;
    end
    rst = r; start = s; write_sig = w; data_in = d;
    model(r, s, w, d);
    @(posedge sys_clk);
    #1;
    chk({tag, ".data_out"}, 32'(data_out), 32'(m_out));
    chk({tag, ".busy"},     32'(busy),     32'(m_busy));
    chk({tag, ".done_sig"}, 32'(done_sig), 32'(m_done));
    if (r) rx_q.delete();
    if (done_sig === 1'b1) begin
      n_done++;
      chk({tag, ".rx_len"}, 32'(rx_q.size()), 32'(NB));
      rx_word = '0;
      for (int i = 0; i < W; i++) if (i < rx_q.size()) rx_word[W-1-i] = rx_q[i];
      chk({tag, ".rx_word"}, 32'(rx_word), 32'(cur_word));
      if (NB > W && rx_q.size() > W) chk({tag, ".rx_parity"}, 32'(rx_q[W]), 32'(^cur_word));
      rx_q.delete();
    end
  endtask

  task automatic send(input logic [W-1:0] d, input int gap, input string tag);
    cyc(1'b0, 1'b1, 1'b0, d, tag);
    for (int i = 0; i < NB; i++) begin
      repeat (gap) cyc(1'b0, 1'b0, 1'b0, '0, tag);
      cyc(1'b0, 1'b0, 1'b1, '0, tag);
    end
  endtask

  typedef struct {
    logic         r, s, w;
    logic [W-1:0] d;
    logic         eo, eb, ed;
  } vec_t;
  vec_t tv[$];

  function automatic void add(input logic r, input logic s, input logic w, input logic [W-1:0] d,
                              input logic eo, input logic eb, input logic ed);
    vec_t v;
    v.r = r; v.s = s; v.w = w; v.d = d; v.eo = eo; v.eb = eb; v.ed = ed;
    tv.push_back(v);
  endfunction

  initial begin
    int nd;
    logic r, s, w;

    // Directed table: reset state, then one full word with expected line levels.
    add(1, 0, 0, 8'h00, 0, 0, 0);
`ifdef WRITE_BUF_PARITY_EN
    // 8'h70 -> 0,1,1,1,0,0,0,0 then parity 1
    add(0, 1, 0, 8'h70, 0, 1, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0);
    add(0, 0, 0, 8'h00, 1, 1, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0);
    add(0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0);
    add(0, 0, 1, 8'h00, 0, 0, 1);
`else
    // 8'h3a -> 0,0,1,1,1,0,1,0
    add(0, 1, 0, 8'h3a, 0, 1, 0);
    add(0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0);
    add(0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0);
    add(0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 1, 8'h00, 0, 0, 1);
`endif
    add(0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 1, 8'h00, 0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].r; start = tv[i].s; write_sig = tv[i].w; data_in = tv[i].d;
      model(tv[i].r, tv[i].s, tv[i].w, tv[i].d);
      @(posedge sys_clk);
      #1;
      chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(tv[i].eo));
      chk($sformatf("vec%0d.busy", i),     32'(busy),     32'(tv[i].eb));
      chk($sformatf("vec%0d.done_sig", i), 32'(done_sig), 32'(tv[i].ed));
    end
    rst = 1'b0; start = 1'b0; write_sig = 1'b0;

    // Loopback of two words, with the receiver checking each.
    nd = n_done;
    send(8'h71, 1, "loop71");
    send(8'hf0, 2, "loopf0");
    chk("loop.done_count", 32'(n_done - nd), 32'd2);

    // Reset mid-word aborts without done_sig; stray pulses afterwards do nothing.
    nd = n_done;
    cyc(0, 1, 0, 8'hf0, "abort");
    repeat (3) cyc(0, 0, 1, '0, "abort");
    cyc(1, 0, 0, '0, "abort.rst");
    chk("abort.line_idle", 32'(data_out), 32'(IV));
    repeat (3) cyc(0, 0, 1, '0, "abort.stray");
    chk("abort.stray_line", 32'(data_out), 32'(IV));
    chk("abort.no_done", 32'(n_done - nd), 32'd0);
    send(8'h0f, 0, "abort.resend");

    // Second start while busy must not disturb the latched word.
    cyc(0, 1, 0, 8'ha5, "busy_start");
    repeat (2) cyc(0, 0, 1, '0, "busy_start");
    cyc(0, 1, 0, 8'h00, "busy_start.ign");
    chk("busy_start.line", 32'(data_out), 32'd1);
    for (int i = 2; i < NB; i++) cyc(0, 0, 1, '0, "busy_start");
    chk("busy_start.done", 32'(done_sig), 32'd1);

    // Coincident start+write_sig in idle: MSB held until the next pulse.
    cyc(0, 1, 1, 8'h80, "coinc");
    chk("coinc.msb", 32'(data_out), 32'd1);
    cyc(0, 0, 0, '0, "coinc.hold");
    chk("coinc.hold_msb", 32'(data_out), 32'd1);
    for (int i = 0; i < NB; i++) cyc(0, 0, 1, '0, "coinc");
    chk("coinc.done", 32'(done_sig), 32'd1);
    // Start during the done_sig cycle is accepted.
    cyc(0, 1, 0, 8'hc3, "done_start");
    chk("done_start.busy", 32'(busy), 32'd1);
    chk("done_start.msb", 32'(data_out), 32'd1);
    for (int i = 0; i < NB; i++) cyc(0, 0, 1, '0, "done_start");

    // Reset wins over start and write_sig.
    cyc(1, 1, 1, 8'hff, "rst_prio");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 7) == 0);
      w = ($urandom_range(0, 2) == 0);
      cyc(r, s, w, W'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
